// File: rtl/clk_div_pkg.sv
// Shared types and constants for the 50%-duty programmable clock divider.
package clk_div_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int DIV_MIN   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/clk_div_n_duty50_if.sv
// Control/status bundle of the divider: run request, divisor load, clock and status outputs.
interface clk_div_n_duty50_if
    import clk_div_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
);

    logic             en;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
    logic             clk_out;
    logic             tick;
    logic [DIV_W-1:0] div_active;
    logic             running;
    logic             cfg_err;

    modport master (
        output en, div_load, div_val,
        input  clk_out, tick, div_active, running, cfg_err
    );

    modport slave (
        input  en, div_load, div_val,
        output clk_out, tick, div_active, running, cfg_err
    );

endinterface

// File: rtl/clk_div_cfg.sv
// Pending/active divisor pair with load validation and the sticky config-error flag.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [DIV_W-1:0] val_i,
    input  logic             upd_i,
    output logic [DIV_W-1:0] active_o,
    output logic             err_o
);

    logic [DIV_W-1:0] pending_q, pending_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic             err_q, err_d;
    logic             valid;

    assign valid = load_i && (val_i >= DIV_W'(DIV_MIN));

    // A load on the same edge as an update is forwarded straight into active.
    always_comb begin
        pending_d = valid ? val_i : pending_q;
        active_d  = upd_i ? pending_d : active_q;
        err_d     = err_q;
        if (load_i) begin
            err_d = !valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= DIV_W'(DIV_RST);
            active_q  <= DIV_W'(DIV_RST);
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            err_q     <= err_d;
        end
    end

    assign active_o = active_q;
    assign err_o    = err_q;

endmodule

// File: rtl/clk_div_n_duty50.sv
// Divide-by-N clock generator with 50% duty for odd and even N, glitch-free divisor switching.
module clk_div_n_duty50
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DIV_RST = 9
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire               VDD,
    inout  wire               VSS,
    clk_div_n_duty50_if.slave bus
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] cnt_cur, half, div_active;
    logic             hi_pos_q, hi_pos_d, hi_neg_q, tick_q;
    logic             at_end, boundary, cfg_upd, cfg_err;
    logic             unused_pwr;

    // Power pins have no function in RTL; this net only sinks them.
    assign unused_pwr = VDD ^ VSS;

    clk_div_cfg #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
    ) u_cfg (
        .clk      (clk),
        .reset    (reset),
        .load_i   (bus.div_load),
        .val_i    (bus.div_val),
        .upd_i    (cfg_upd),
        .active_o (div_active),
        .err_o    (cfg_err)
    );

    assign half     = (div_active >> 1) + DIV_W'(div_active[0]);
    assign cnt_cur  = (state_q == RUN) ? count_q : '0;
    assign at_end   = (cnt_cur == div_active - DIV_W'(1));
    assign boundary = (state_q == RUN) && at_end;
    assign cfg_upd  = (state_q == IDLE) || boundary;

    // Entering RUN applies the ordinary run update from count 0, so the first
    // high phase begins on the entry edge.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_pos_d = hi_pos_q;
        if ((state_q == RUN) || bus.en) begin
            state_d  = RUN;
            count_d  = at_end ? '0 : cnt_cur + DIV_W'(1);
            hi_pos_d = (cnt_cur < half);
        end
        if (boundary && !bus.en) begin
            state_d  = IDLE;
            count_d  = '0;
            hi_pos_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            hi_pos_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_pos_q <= hi_pos_d;
            tick_q   <= hi_pos_d & ~hi_pos_q;
        end
    end

    // Half-cycle delayed copy; ANDing it trims half a cycle off odd-N high phases.
    always_ff @(negedge clk) begin
        if (reset) begin
            hi_neg_q <= 1'b0;
        end else begin
            hi_neg_q <= hi_pos_q;
        end
    end

    assign bus.clk_out    = div_active[0] ? (hi_pos_q & hi_neg_q) : hi_pos_q;
    assign bus.tick       = tick_q;
    assign bus.div_active = div_active;
    assign bus.running    = (state_q == RUN);
    assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_clk_div_n_duty50.sv
// Directed and random stimulus against a half-cycle-slot reference model of the divider.
module tb_clk_div_n_duty50;

    localparam int W    = 8;
    localparam int NRST = 9;

    logic clk = 1'b0;
    logic reset;
    wire  vdd = 1'b1;
    wire  vss = 1'b0;

    clk_div_n_duty50_if #(.DIV_W(W)) bus ();

    clk_div_n_duty50 #(
        .DIV_W   (W),
        .DIV_RST (NRST)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .VDD   (vdd),
        .VSS   (vss),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    // Model: m_e is the index of the last rising edge within its period,
    // m_pn the divisor of that period, m_n the divisor in force.
    bit m_run, m_err, m_tick, m_inp;
    int m_n, m_pend, m_pn, m_e, m_nxt;

    // Period of 2N half-cycle slots from the period's first rising edge:
    // even N is high in slots 0..N-1, odd N is high in slots 1..N.
    function automatic bit hi_slot(input int n, input int s);
        if ((n % 2) == 1) return (s >= 1) && (s <= n);
        return s < n;
    endfunction

    task automatic model(input bit r, input bit e, input bit l, input int v);
        if (r) begin
            m_run = 0; m_err = 0; m_tick = 0; m_inp = 0;
            m_n = NRST; m_pend = NRST; m_pn = NRST; m_e = 0; m_nxt = 0;
            return;
        end
        if (l) begin
            if (v >= 2) begin
                m_pend = v;
                m_err  = 0;
            end else begin
                m_err = 1;
            end
        end
        m_tick = 0;
        if (m_run) begin
            m_e   = m_nxt;
            m_inp = 1;
            if (m_e == 0) begin
                m_pn   = m_n;
                m_tick = 1;
            end
            if (m_e == m_pn - 1) begin
                m_n   = m_pend;
                m_nxt = 0;
                if (!e) m_run = 0;
            end else begin
                m_nxt = m_e + 1;
            end
        end else begin
            m_n = m_pend;
            if (e) begin
                m_run = 1; m_inp = 1; m_tick = 1;
                m_e = 0; m_nxt = 1; m_pn = m_n;
            end else begin
                m_inp = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc_n, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit e, input bit l, input int v);
        reset        = r;
        bus.en       = e;
        bus.div_load = l;
        bus.div_val  = W'(v);
        @(posedge clk);
        model(r, e, l, v & 255);
        cyc_n++;
        #1;
        chk("clk_out_pos", 32'(bus.clk_out), 32'(m_inp && hi_slot(m_pn, 2 * m_e)));
        chk("tick", 32'(bus.tick), 32'(m_tick));
        chk("running", 32'(bus.running), 32'(m_run));
        chk("div_active", 32'(bus.div_active), 32'(m_n));
        chk("cfg_err", 32'(bus.cfg_err), 32'(m_err));
        @(negedge clk);
        #1;
        chk("clk_out_neg", 32'(bus.clk_out), 32'(m_inp && hi_slot(m_pn, 2 * m_e + 1)));
    endtask

    task automatic run(input int k, input bit e);
        repeat (k) cyc(0, e, 0, 0);
    endtask

    // Advance with en=1 until the next rising edge will be edge 'target' of a period.
    task automatic run_until(input int target, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            if (m_run && (m_nxt == target)) begin
                ok = 1;
                break;
            end
            cyc(0, 1, 0, 0);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        bit r, e, l;
        int v;

        reset = 1; bus.en = 0; bus.div_load = 0; bus.div_val = '0;

        // Reset state, then free-running at the reset divisor of 9.
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 1);
        run(3, 0);
        run(30, 1);

        // Mid-period loads of 12, then 80.
        run(4, 1);
        cyc(0, 1, 1, 12);
        run(40, 1);
        cyc(0, 1, 1, 80);
        run(200, 1);

        // Back to 9, rejected load of 1, then a valid load of 10.
        cyc(0, 1, 1, 9);
        run(100, 1);
        cyc(0, 1, 1, 1);
        run(20, 1);
        cyc(0, 1, 1, 10);
        run(30, 1);

        // Drop en while clk_out is high at N=9.
        cyc(0, 1, 1, 9);
        run(25, 1);
        run_until(3, "wait_hi_phase");
        run(15, 0);

        // One-cycle reset at count 5 with en held high.
        run_until(5, "wait_count5");
        cyc(1, 1, 0, 0);
        run(25, 1);

        // Load of 2 on the boundary edge itself.
        run_until(m_pn - 1, "wait_boundary");
        cyc(0, 1, 1, 2);
        run(10, 1);
        cyc(0, 1, 1, 7);
        run(20, 1);

        // Random en, loads (some invalid) and occasional reset.
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 7) != 0);
            l = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 1));
            else v = int'($urandom_range(2, 16));
            cyc(r, e, l, v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
